// File: rtl/adc_demod_core.sv
// Synchronous PWM demodulator for XADC auxiliary channels: reads each conversion over DRP,
// accumulates on/off phase sums per channel and emits their signed difference.
module adc_demod_core #(
  parameter int unsigned NUM_CH   = 1,
  parameter int unsigned BASE_CH  = 16,
  parameter int unsigned AVG_LOG2 = 4,
  parameter int unsigned SETTLE   = 0,
  localparam int unsigned RW      = 12 + AVG_LOG2 + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 switch_pwm,
  input  logic                 eoc,
  input  logic [4:0]           channel_in,
  output logic                 den,
  output logic [6:0]           daddr,
  input  logic                 drdy,
  input  logic [15:0]          do_data,
  output logic                 res_valid,
  output logic [1:0]           res_ch,
  output logic signed [RW-1:0] res_data,
  output logic [3:0]           LED,
  output logic                 overrun,
  output logic                 timeout
);

  localparam int unsigned AW = 12 + AVG_LOG2;
  localparam int unsigned CW = AVG_LOG2 + 1;
  localparam int unsigned SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(1) << AVG_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ACC} state_t;

  state_t         state_q, state_d;
  logic           pwm_m, pwm_s;
  logic [SW-1:0]  settle;
  logic [7:0]     wait_cnt;
  logic [1:0]     ch_q;
  logic [11:0]    sample_q;
  logic           phase_q;
  logic           keep_q;
  logic           fire;
  logic [1:0]     fire_ch;
  logic [AW-1:0]  on_acc  [4];
  logic [AW-1:0]  off_acc [4];
  logic [CW-1:0]  on_cnt  [4];
  logic [CW-1:0]  off_cnt [4];
  logic           ch_hit;
  logic signed [RW-1:0] diff;
  logic [3:0]     led_nx;
  logic           unused_bits;

  assign unused_bits = ^do_data[3:0];
  assign ch_hit = (32'(channel_in) >= BASE_CH) && (32'(channel_in) < BASE_CH + NUM_CH);
  assign diff   = $signed({1'b0, on_acc[fire_ch]}) - $signed({1'b0, off_acc[fire_ch]});

  // Bar graph: result is always below FS, so the top four magnitude bits pick the step
  always_comb begin
    led_nx = 4'b0000;
    if (!diff[RW-1]) begin
      if (diff[AW-1])      led_nx = 4'b1111;
      else if (diff[AW-2]) led_nx = 4'b0111;
      else if (diff[AW-3]) led_nx = 4'b0011;
      else if (diff[AW-4]) led_nx = 4'b0001;
    end
  end

  // PWM synchroniser and post-edge settle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_m  <= 1'b0;
      pwm_s  <= 1'b0;
      settle <= '0;
    end else begin
      pwm_m <= switch_pwm;
      pwm_s <= pwm_m;
      if (pwm_m != pwm_s)    settle <= SW'(SETTLE);
      else if (settle != '0) settle <= settle - SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (eoc && ch_hit) state_d = S_REQ;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        if (drdy)                  state_d = S_ACC;
        else if (wait_cnt == 8'hFF) state_d = S_IDLE;
      end
      S_ACC:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      den       <= 1'b0;
      daddr     <= '0;
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_data  <= '0;
      LED       <= '0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
      wait_cnt  <= '0;
      ch_q      <= '0;
      sample_q  <= '0;
      phase_q   <= 1'b0;
      keep_q    <= 1'b0;
      fire      <= 1'b0;
      fire_ch   <= '0;
      for (int i = 0; i < 4; i++) begin
        on_acc[i]  <= '0;
        off_acc[i] <= '0;
        on_cnt[i]  <= '0;
        off_cnt[i] <= '0;
      end
    end else begin
      den       <= (state_d == S_REQ);
      res_valid <= 1'b0;
      fire      <= 1'b0;
      wait_cnt  <= (state_q == S_WAIT) ? wait_cnt + 8'd1 : 8'd0;

      if (state_q == S_IDLE && state_d == S_REQ) begin
        ch_q  <= 2'(channel_in - 5'(BASE_CH));
        daddr <= {2'b00, channel_in};
      end
      if (eoc && state_q != S_IDLE) overrun <= 1'b1;

      if (state_q == S_WAIT) begin
        if (drdy) begin
          sample_q <= do_data[15:4];
          phase_q  <= pwm_s;
          keep_q   <= (settle == '0);
        end else if (wait_cnt == 8'hFF) begin
          timeout <= 1'b1;
        end
      end

      // Accumulate; flag completion when this sample fills the last open phase
      if (state_q == S_ACC) begin
        fire_ch <= ch_q;
        if (keep_q && phase_q && on_cnt[ch_q] != CNT_FULL) begin
          on_acc[ch_q] <= on_acc[ch_q] + AW'(sample_q);
          on_cnt[ch_q] <= on_cnt[ch_q] + CW'(1);
          fire <= (on_cnt[ch_q] == CNT_FULL - CW'(1)) && (off_cnt[ch_q] == CNT_FULL);
        end else if (keep_q && !phase_q && off_cnt[ch_q] != CNT_FULL) begin
          off_acc[ch_q] <= off_acc[ch_q] + AW'(sample_q);
          off_cnt[ch_q] <= off_cnt[ch_q] + CW'(1);
          fire <= (off_cnt[ch_q] == CNT_FULL - CW'(1)) && (on_cnt[ch_q] == CNT_FULL);
        end
      end

      if (fire) begin
        res_valid        <= 1'b1;
        res_ch           <= fire_ch;
        res_data         <= diff;
        on_acc[fire_ch]  <= '0;
        off_acc[fire_ch] <= '0;
        on_cnt[fire_ch]  <= '0;
        off_cnt[fire_ch] <= '0;
        if (fire_ch == 2'd0) LED <= led_nx;
      end
    end
  end

endmodule

// File: tb/tb_adc_demod_core.sv
// Directed bench for adc_demod_core: DRP/XADC handshake driven by tasks, results checked
// against a per-channel on/off accumulation model through an expected-result queue.
module tb_adc_demod_core;

  localparam int unsigned RW = 15;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 switch_pwm;
  logic                 eoc;
  logic [4:0]           channel_in;
  logic                 den;
  logic [6:0]           daddr;
  logic                 drdy;
  logic [15:0]          do_data;
  logic                 res_valid;
  logic [1:0]           res_ch;
  logic signed [RW-1:0] res_data;
  logic [3:0]           LED;
  logic                 overrun;
  logic                 timeout;

  adc_demod_core #(.NUM_CH(2), .BASE_CH(16), .AVG_LOG2(2), .SETTLE(50)) dut (
    .clk(clk), .rst(rst), .switch_pwm(switch_pwm), .eoc(eoc), .channel_in(channel_in),
    .den(den), .daddr(daddr), .drdy(drdy), .do_data(do_data), .res_valid(res_valid),
    .res_ch(res_ch), .res_data(res_data), .LED(LED), .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int data; int due; } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int m_on [2];
  int m_off[2];
  int m_onc[2];
  int m_offc[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_on[i] = 0; m_off[i] = 0; m_onc[i] = 0; m_offc[i] = 0;
    end
  endtask

  // Four samples per phase complete a set; extras in a full phase are dropped
  task automatic model(input int ch, input int s, input bit ph, input bit kept, input int due);
    if (kept) begin
      if (ph && m_onc[ch] < 4) begin
        m_on[ch] += s; m_onc[ch]++;
      end else if (!ph && m_offc[ch] < 4) begin
        m_off[ch] += s; m_offc[ch]++;
      end
      if (m_onc[ch] == 4 && m_offc[ch] == 4) begin
        exp_q.push_back('{ch, m_on[ch] - m_off[ch], due});
        m_on[ch] = 0; m_off[ch] = 0; m_onc[ch] = 0; m_offc[ch] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_res_valid", 32'(res_ch), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_ch", 32'(res_ch), 32'(e.ch));
        chk("res_data", 32'(res_data), 32'(e.data));
        chk("latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic set_pwm(input logic v);
    switch_pwm = v;
    repeat (60) @(negedge clk);
  endtask

  task automatic wait_den(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (den) seen = 1'b1;
      else @(negedge clk);
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  // One conversion: eoc, DRP request, optional stray eoc in WAIT, then drdy after gap cycles
  task automatic do_sample(input int ch, input logic [11:0] s, input bit ph, input bit kept,
                           input int gap, input bit ovr);
    @(negedge clk); channel_in = 5'(16 + ch); eoc = 1'b1;
    @(negedge clk); eoc = 1'b0;
    wait_den("den_seen");
    chk("daddr", 32'(daddr), 32'(16 + ch));
    @(negedge clk);
    if (ovr) begin
      eoc = 1'b1; channel_in = 5'd16;
      @(negedge clk); eoc = 1'b0;
      chk("den_quiet_on_overrun", 32'(den), 32'd0);
    end
    repeat (gap) @(negedge clk);
    drdy = 1'b1; do_data = {s, 4'hA};
    model(ch, int'(s), ph, kept, cyc + 3);
    @(negedge clk); drdy = 1'b0; do_data = 16'h0;
    repeat (4) @(negedge clk);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_den"}, 32'(den), 32'd0);
    chk({tag, "_daddr"}, 32'(daddr), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_ch"}, 32'(res_ch), 32'd0);
    chk({tag, "_res_data"}, 32'(res_data), 32'd0);
    chk({tag, "_led"}, 32'(LED), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    rst = 1'b1; switch_pwm = 1'b0; eoc = 1'b0; channel_in = '0; drdy = 1'b0; do_data = '0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_chk("reset");
    rst = 1'b0;

    // +6144: 4 x 0x800 on, 4 x 0x200 off
    set_pwm(1'b1);
    for (int i = 0; i < 4; i++) do_sample(0, 12'h800, 1'b1, 1'b1, 2, 1'b0);
    set_pwm(1'b0);
    for (int i = 0; i < 4; i++) do_sample(0, 12'h200, 1'b0, 1'b1, 2, 1'b0);
    chk("led_6144", 32'(LED), 32'b0111);

    // -8192 with a fifth on sample dropped
    set_pwm(1'b1);
    for (int i = 0; i < 5; i++) do_sample(0, 12'h100, 1'b1, 1'b1, 1, 1'b0);
    set_pwm(1'b0);
    for (int i = 0; i < 4; i++) do_sample(0, 12'h900, 1'b0, 1'b1, 3, 1'b0);
    chk("led_neg", 32'(LED), 32'b0000);
    chk("overrun_clear", 32'(overrun), 32'd0);

    // Overrun during WAIT, then a read that times out
    set_pwm(1'b1);
    do_sample(0, 12'hC00, 1'b1, 1'b1, 2, 1'b1);
    chk("overrun_set", 32'(overrun), 32'd1);
    for (int i = 0; i < 3; i++) do_sample(0, 12'hC00, 1'b1, 1'b1, 2, 1'b0);
    @(negedge clk); channel_in = 5'd16; eoc = 1'b1;
    @(negedge clk); eoc = 1'b0;
    wait_den("den_timeout_read");
    repeat (200) @(negedge clk);
    chk("timeout_early", 32'(timeout), 32'd0);
    repeat (70) @(negedge clk);
    chk("timeout_set", 32'(timeout), 32'd1);
    set_pwm(1'b0);
    for (int i = 0; i < 4; i++) do_sample(0, 12'h000, 1'b0, 1'b1, 2, 1'b0);
    chk("led_12288", 32'(LED), 32'b1111);

    // Settle window: drdy ~10 cycles after the edge is dropped, ~60 cycles is kept
    switch_pwm = 1'b1;
    do_sample(0, 12'hFFF, 1'b1, 1'b0, 6, 1'b0);
    repeat (36) @(negedge clk);
    for (int i = 0; i < 4; i++) do_sample(0, 12'h300, 1'b1, 1'b1, 6, 1'b0);
    set_pwm(1'b0);
    for (int i = 0; i < 4; i++) do_sample(0, 12'h100, 1'b0, 1'b1, 2, 1'b0);
    chk("led_2048", 32'(LED), 32'b0011);

    // Two interleaved channels; channel 1 must not move the bar graph
    set_pwm(1'b1);
    for (int i = 0; i < 4; i++) begin
      do_sample(0, 12'h800, 1'b1, 1'b1, 1, 1'b0);
      do_sample(1, 12'h050, 1'b1, 1'b1, 2, 1'b0);
    end
    set_pwm(1'b0);
    for (int i = 0; i < 4; i++) begin
      do_sample(0, 12'h000, 1'b0, 1'b1, 1, 1'b0);
      do_sample(1, 12'h0A0, 1'b0, 1'b1, 2, 1'b0);
    end
    chk("led_8192_ch1_ignored", 32'(LED), 32'b1111);

    // Out-of-range channel issues no DRP read; result outputs hold
    @(negedge clk); channel_in = 5'd20; eoc = 1'b1;
    @(negedge clk); eoc = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen |= den;
      @(negedge clk);
    end
    chk("no_den_ch20", 32'(seen), 32'd0);
    chk("hold_res_ch", 32'(res_ch), 32'd1);
    chk("hold_res_data", 32'(res_data), 32'(-320));

    // Reset mid-set and mid-read; late drdy ignored, then a clean set
    set_pwm(1'b1);
    for (int i = 0; i < 3; i++) do_sample(0, 12'h700, 1'b1, 1'b1, 2, 1'b0);
    @(negedge clk); channel_in = 5'd16; eoc = 1'b1;
    @(negedge clk); eoc = 1'b0;
    wait_den("den_before_rst");
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; drdy = 1'b1; do_data = 16'hFFF0;
    @(negedge clk); drdy = 1'b0; do_data = 16'h0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_chk("mid_reset");
    set_pwm(1'b1);
    for (int i = 0; i < 4; i++) do_sample(0, 12'h200, 1'b1, 1'b1, 2, 1'b0);
    set_pwm(1'b0);
    for (int i = 0; i < 4; i++) do_sample(0, 12'h100, 1'b0, 1'b1, 2, 1'b0);
    chk("led_1024", 32'(LED), 32'b0001);

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
